// File: rtl/sc_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty levels and
// overflow/underflow pulses. Define SC_FIFO_FWFT_EN for first-word-fall-through dout.
module sc_fifo_prog #(
  parameter int DW     = 8,
  parameter int DEPTH  = 6,
  parameter int AF_LVL = 5,
  parameter int AE_LVL = 1,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          write,
  input  logic [DW-1:0] din,
  input  logic          read,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] data_cnt,
  output logic          overflow,
  output logic          underflow
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          wr_ok, rd_ok;

  assign full         = (cnt_q == CW'(DEPTH));
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= CW'(AF_LVL));
  assign almost_empty = (cnt_q <= CW'(AE_LVL));
  assign data_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_ok = write & ~full;
  assign rd_ok = read & ~empty;

  // Depth need not be a power of two, so wrap on an explicit compare.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
    if (rd_ok) rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
    if (wr_ok && !rd_ok)      cnt_d = cnt_q + CW'(1);
    else if (rd_ok && !wr_ok) cnt_d = cnt_q - CW'(1);
    ovf_d = write & full;
    unf_d = read & empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din;
  end

`ifdef SC_FIFO_FWFT_EN
  // Head is gated to zero while empty so the output is stable and clean out of reset.
  assign dout = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [DW-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_ok) dout_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign dout = dout_q;
`endif
endmodule
